// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline
// write-enable / flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    HOLD
  } state_e;

  typedef enum logic [2:0] {
    EXC,
    FREEZE,
    REDIR,
    STALL,
    FLOW
  } rule_e;

  localparam logic FLUSH_ENABLE = 1'b1;
  localparam logic CACHE_BUSY   = 1'b1;

endpackage

// File: rtl/pipe_stall_decode.sv
// Local stall decode: the oldest stalling stage
// freezes itself and everything younger.
module pipe_stall_decode #(
  parameter int NUM_REGS = 7
) (
  input  logic [NUM_REGS-1:0] stall_req,
  output logic [NUM_REGS-1:0] wr,
  output logic [NUM_REGS-1:0] flush
);

  logic found;
  int   k;

  // highest set stall bit, then freeze 0..k and bubble k+1
  always_comb begin
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (stall_req[i]) begin
        found = 1'b1;
        k     = i;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      wr[i]    = !found || (i > k);
      flush[i] = found && (i == k + 1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline write-enable / flush controller with
// redirect replay, stall counter and hang watchdog.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 7,
  parameter int NUM_CACHES = 2,
  parameter int EXC_STAGE  = 4,
  parameter logic [NUM_REGS-1:0] REDIRECT_FLUSH_MASK =
    NUM_REGS'('b0000100),
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REGS-1:0]   stall_req,
  input  logic [NUM_CACHES-1:0] cache_busy,
  input  logic                  exc_req,
  input  logic                  redirect_req,
  input  logic                  cnt_clr,
  output logic [NUM_REGS-1:0]   wr,
  output logic [NUM_REGS-1:0]   flush,
  output logic                  commit_block,
  output logic                  icache_flush,
  output logic                  dcache_flush,
  output logic                  redirect_fire,
  output logic                  redirect_pend,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  hang
);

  localparam int HW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] TMO = HW'(TIMEOUT);

  state_e state_q, state_n;
  rule_e  rule;

  logic                busy;
  logic                pend_q, pend_n;
  logic                hold_cond;
  logic [HW-1:0]       hold_q, hold_n;
  logic                hang_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REGS-1:0] st_wr, st_fl;
  logic [NUM_REGS-1:0] exc_wr, exc_fl;
  logic [NUM_REGS-1:0] redir_fl;
  logic [NUM_REGS-1:0] wr_c, fl_c;
  logic                cb_c, icf_c, dcf_c, fire_c;

  pipe_stall_decode #(
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .stall_req (stall_req),
    .wr        (st_wr),
    .flush     (st_fl)
  );

  assign busy = |(cache_busy & {NUM_CACHES{CACHE_BUSY}});
  assign redir_fl = {REDIRECT_FLUSH_MASK[NUM_REGS-1:1], 1'b0};

  // exception squashes 1..EXC_STAGE, older stages retire
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      exc_fl[i] = (i >= 1) && (i <= EXC_STAGE);
      exc_wr[i] = (i == 0) || (i > EXC_STAGE);
    end
  end

  // priority rule select
  always_comb begin
    rule = FLOW;
    if (exc_req)
      rule = EXC;
    else if (busy)
      rule = FREEZE;
    else if ((pend_q || redirect_req) && stall_req == '0)
      rule = REDIR;
    else if (stall_req != '0)
      rule = STALL;
  end

  // per-rule outputs and redirect latch
  always_comb begin
    wr_c      = '1;
    fl_c      = '0;
    cb_c      = 1'b0;
    icf_c     = 1'b0;
    dcf_c     = 1'b0;
    fire_c    = 1'b0;
    hold_cond = 1'b0;
    pend_n    = pend_q;
    unique case (rule)
      EXC: begin
        wr_c   = exc_wr;
        fl_c   = exc_fl;
        icf_c  = FLUSH_ENABLE;
        dcf_c  = FLUSH_ENABLE;
        pend_n = 1'b0;
      end
      FREEZE: begin
        wr_c      = '0;
        cb_c      = 1'b1;
        hold_cond = 1'b1;
        pend_n    = pend_q | redirect_req;
      end
      REDIR: begin
        fl_c   = redir_fl;
        icf_c  = FLUSH_ENABLE;
        fire_c = 1'b1;
        pend_n = 1'b0;
      end
      STALL: begin
        wr_c      = st_wr;
        fl_c      = st_fl;
        hold_cond = 1'b1;
        pend_n    = pend_q | redirect_req;
      end
      default: ;
    endcase
  end

  // freeze tracking FSM
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RUN:     if (busy && !exc_req) state_n = HOLD;
      HOLD:    if (exc_req || !busy) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // contiguous hold length, saturating at the timeout
  always_comb begin
    hold_n = '0;
    if (hold_cond)
      hold_n = (hold_q == TMO) ? TMO : hold_q + HW'(1);
  end

  // state, pending redirect, watchdog and stall counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      hold_q  <= '0;
      hang_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      hold_q  <= hold_n;
      if (hold_n == TMO)
        hang_q <= 1'b1;
      if (cnt_clr)
        cnt_q <= '0;
      else if (!(&wr_c) && !(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign wr            = resetn ? wr_c : '0;
  assign flush         = resetn ? fl_c : '0;
  assign commit_block  = resetn & cb_c;
  assign icache_flush  = resetn & icf_c;
  assign dcache_flush  = resetn & dcf_c;
  assign redirect_fire = resetn & fire_c;
  assign redirect_pend = pend_q;
  assign stall_cnt     = cnt_q;
  assign hang          = resetn & (hang_q | (hold_n == TMO));

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the fixed seven-stage write-enable/flush controller.
- Generates per-register write enables and flushes for an N-register pipeline from these requests:
  - per-stage stall requests
  - a cache-busy vector (any number of caches)
  - an exception pulse
  - a branch-redirect pulse
- Adds state the previous block lacked: a redirect raised while caches are busy is latched and replayed later, never dropped. A stall-cycle counter and a hang watchdog are also added.
- Sits beside the datapath. All outputs are combinational from current inputs plus internal registers.

Parameters:
- NUM_REGS, 7, pipeline registers. Index 0 = PC (PreIF), NUM_REGS-1 = WB register. Lower index = younger.
- NUM_CACHES, 2, width of the cache busy vector (I$, D$, ...).
- EXC_STAGE, 4, highest register index flushed on exception. Must satisfy 1..NUM_REGS-1.
- REDIRECT_FLUSH_MASK, 7'b0000100, registers flushed when a redirect fires. Bit 0 is ignored.
- CNT_W, 32, width of the stall counter.
- TIMEOUT, 1024, contiguous hold cycles before hang asserts. Must be ≥1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- stall_req  in  NUM_REGS  local stall request from stage i (data hazard, mul/div busy)
- cache_busy  in  NUM_CACHES  global freeze request, 1 = busy
- exc_req  in  1  exception commit pulse
- redirect_req  in  1  branch mispredict / immediate-jump pulse, one cycle wide
- cnt_clr  in  1  synchronous clear of stall_cnt
- wr  out  NUM_REGS  pipeline register write enables
- flush  out  NUM_REGS  pipeline register flushes (bubble insert)
- commit_block  out  1  disables RF/CP0 writes in MEM/WB during a freeze
- icache_flush  out  1
- dcache_flush  out  1
- redirect_fire  out  1  pulse in the cycle a live or pending redirect is applied
- redirect_pend  out  1  a redirect is latched and awaiting application
- stall_cnt  out  CNT_W  saturating count of cycles with any wr bit 0
- hang  out  1  sticky watchdog flag

Behaviour:
- Reset (resetn=0, asynchronous):
  - Outputs: wr=0, flush=0, all 1-bit outputs 0, stall_cnt=0.
  - Internal: pend=0, hold_cnt=0, state=RUN.
- Per-cycle priority (first matching rule wins):
  1. exc_req=1:
     - wr[0]=1; flush[1..EXC_STAGE]=1.
     - wr[j]=1 for all j>EXC_STAGE; flush elsewhere 0.
     - icache_flush=dcache_flush=1; commit_block=0.
     - pend cleared; redirect_req ignored; redirect_fire=0. Next state RUN.
  2. |cache_busy:
     - wr=0, flush=0, commit_block=1, icache_flush=0.
     - A redirect_req this cycle sets pend. Next state HOLD.
  3. (pend|redirect_req) and stall_req==0:
     - wr=all 1; flush=REDIRECT_FLUSH_MASK with bit 0 forced 0.
     - icache_flush=1; redirect_fire=1; pend cleared.
  4. stall_req≠0, with k = highest set index:
     - wr[0..k]=0; flush[k+1]=1 if k<NUM_REGS-1; all other wr=1.
     - A live redirect_req sets pend.
  5. Otherwise: wr=all 1, flush=0.
- dcache_flush is 1 only under rule 1.
- redirect_pend = pend register.
- FSM:
  - States: RUN, HOLD.
  - RUN→HOLD when busy and no exception.
  - HOLD→RUN on the first non-busy cycle. That cycle evaluates rules 3-5 normally, so a pending redirect applies on exactly that cycle if no local stall.
- A simultaneous redirect_req and pend produce a single redirect_fire.
- stall_cnt:
  - Increments when resetn=1 and any wr bit is 0.
  - Saturates at all-ones.
  - cnt_clr has priority over increment.
- hold_cnt:
  - Counts contiguous cycles of rule 2 or 4; zeroed on any other cycle.
  - hang sets when hold_cnt reaches TIMEOUT and is cleared only by reset.
  - hold_cnt saturates at TIMEOUT.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, HOLD}
  - the rule-select enum (EXC, FREEZE, REDIR, STALL, FLOW)
  - the FLUSH_ENABLE and CACHE_BUSY constants
- One sub-module, pipe_stall_decode: combinational. Maps stall_req to the (wr, flush) vectors via a highest-set-bit search, parameterised by NUM_REGS.

Test Plan (defaults):
- stall_req=7'b0001000 → wr=7'b1110000, flush=7'b0010000, stall_cnt +1 per cycle.
- cache_busy=2'b01 for 3 cycles, redirect_req pulse in cycle 2, then busy=0 → redirect_pend=1 during the remaining busy cycle; on the first free cycle redirect_fire=1, flush=7'b0000100, icache_flush=1; pend=0 afterwards.
- exc_req together with cache_busy=2'b10 and pend=1 → wr[0]=1, flush=7'b0011110, wr[6:5]=2'b11, icache_flush=dcache_flush=1, commit_block=0, pend cleared.
- redirect_req while stall_req=7'b0000100 → no fire, pend=1; when stall drops next cycle → redirect_fire=1.
- TIMEOUT=8 with busy held 8 cycles → hang=1 on the 8th cycle and stays 1 after busy drops; assert resetn=0 mid-hold → all outputs 0 immediately (asynchronous).
- stall_cnt preloaded near saturation (CNT_W=4: 15 stall cycles then more) → holds 4'hF; cnt_clr together with a stall → 0 next cycle.
